// File: rtl/soc_gpio_pkg.sv
// soc_gpio_pkg: shared constants for the soc_gpio register window.
// Holds the byte addresses of the four decoded registers. Every other
// 4-bit address is unmapped: it reads as zero and ignores writes.
package soc_gpio_pkg;

  localparam logic [3:0] GPIO_ADDR_MODE = 4'h0;  // direction, read/write
  localparam logic [3:0] GPIO_ADDR_OUT  = 4'h4;  // output data, read/write
  localparam logic [3:0] GPIO_ADDR_IN   = 4'h8;  // pin levels, read-only
  localparam logic [3:0] GPIO_ADDR_TGL  = 4'hC;  // XOR into OUT, write-only

endpackage

// File: rtl/soc_gpio_sync.sv
// gpio_sync: parameterized-width two-flop synchronizer for asynchronous pin
// inputs. Both stages clear to zero under reset.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   din  - asynchronous input bus
//   dout - synchronized output, two rising edges after din is sampled
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture chain; the first stage may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign dout = sync_r;

endmodule

// File: rtl/soc_gpio.sv
// soc_gpio: memory-mapped GPIO block with a 4-bit byte-addressed register
// window (MODE, OUT, IN, OUT_TGL). Writes take effect on the edge that
// samples gpio_we; reads are registered and always return the value held
// before any write in the same cycle.
// Build option: define SOC_GPIO_IN_SYNC_EN to route gpio_in through a
// two-flop synchronizer before the IN register (3-edge pin-to-rdata latency).
// Ports:
//   clk        - clock, rising edge active
//   rst        - asynchronous active-high reset
//   gpio_wdata - write data (only the low NUM_GPIO bits are used)
//   gpio_we    - write enable
//   gpio_addr  - register byte address
//   gpio_rdata - registered read data, zero-extended
//   gpio_ready - 0 in reset, 1 from the first edge after reset onward
//   gpio_mode  - per-pin direction, 1 = output
//   gpio_out   - output data register, not masked by gpio_mode
//   gpio_in    - pin input levels
module soc_gpio
  import soc_gpio_pkg::*;
#(
  parameter int IO_MAP_WIDTH = 32,
  parameter int NUM_GPIO     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IO_MAP_WIDTH-1:0] gpio_wdata,
  input  logic                    gpio_we,
  input  logic [3:0]              gpio_addr,
  output logic [IO_MAP_WIDTH-1:0] gpio_rdata,
  output logic                    gpio_ready,
  output logic [NUM_GPIO-1:0]     gpio_mode,
  output logic [NUM_GPIO-1:0]     gpio_out,
  input  logic [NUM_GPIO-1:0]     gpio_in
);

  logic [NUM_GPIO-1:0]     mode_r;
  logic [NUM_GPIO-1:0]     out_r;
  logic [IO_MAP_WIDTH-1:0] rdata_r;
  logic                    ready_r;

  logic [NUM_GPIO-1:0]     wdata_s;
  logic [NUM_GPIO-1:0]     in_val_s;
  logic [NUM_GPIO-1:0]     mode_next_s;
  logic [NUM_GPIO-1:0]     out_next_s;
  logic [IO_MAP_WIDTH-1:0] rdata_next_s;
  logic                    unused_wdata_s;

  assign wdata_s = gpio_wdata[NUM_GPIO-1:0];
  // Bits above NUM_GPIO carry no meaning; fold them so they are not dangling.
  assign unused_wdata_s = ^gpio_wdata;

`ifdef SOC_GPIO_IN_SYNC_EN
  gpio_sync #(
    .WIDTH (NUM_GPIO)
  ) u_in_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_in),
    .dout (in_val_s)
  );
`else
  assign in_val_s = gpio_in;
`endif

  // Write decode: MODE/OUT load, OUT_TGL XORs into OUT, others ignored.
  always_comb begin
    mode_next_s = mode_r;
    out_next_s  = out_r;
    if (gpio_we) begin
      case (gpio_addr)
        GPIO_ADDR_MODE: mode_next_s = wdata_s;
        GPIO_ADDR_OUT:  out_next_s  = wdata_s;
        GPIO_ADDR_TGL:  out_next_s  = out_r ^ wdata_s;
        default: begin
          mode_next_s = mode_r;
          out_next_s  = out_r;
        end
      endcase
    end else begin
      mode_next_s = mode_r;
      out_next_s  = out_r;
    end
  end

  // Read mux built from current register values, so a same-cycle write is
  // not visible in the data captured on that edge.
  always_comb begin
    rdata_next_s = {IO_MAP_WIDTH{1'b0}};
    case (gpio_addr)
      GPIO_ADDR_MODE: rdata_next_s = IO_MAP_WIDTH'(mode_r);
      GPIO_ADDR_OUT:  rdata_next_s = IO_MAP_WIDTH'(out_r);
      GPIO_ADDR_IN:   rdata_next_s = IO_MAP_WIDTH'(in_val_s);
      default:        rdata_next_s = {IO_MAP_WIDTH{1'b0}};
    endcase
  end

  // Register file, read data and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= {NUM_GPIO{1'b0}};
      out_r   <= {NUM_GPIO{1'b0}};
      rdata_r <= {IO_MAP_WIDTH{1'b0}};
      ready_r <= 1'b0;
    end else begin
      mode_r  <= mode_next_s;
      out_r   <= out_next_s;
      rdata_r <= rdata_next_s;
      ready_r <= 1'b1;
    end
  end

  assign gpio_mode  = mode_r;
  assign gpio_out   = out_r;
  assign gpio_rdata = rdata_r;
  assign gpio_ready = ready_r;

endmodule

// File: tb/tb_soc_gpio.sv
// tb_soc_gpio: randomized, scoreboard-based bench for soc_gpio.
// The driver applies one bus cycle per clock on the falling edge and pushes
// the response expected after the next rising edge; a separate monitor pops
// and compares one entry per rising edge while the block is out of reset.
module tb_soc_gpio;

  localparam int W = 32;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gpio_wdata;
  logic         gpio_we;
  logic [3:0]   gpio_addr;
  logic [W-1:0] gpio_rdata;
  logic         gpio_ready;
  logic [N-1:0] gpio_mode;
  logic [N-1:0] gpio_out;
  logic [N-1:0] gpio_in;

  soc_gpio #(
    .IO_MAP_WIDTH (W),
    .NUM_GPIO     (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_wdata (gpio_wdata),
    .gpio_we    (gpio_we),
    .gpio_addr  (gpio_addr),
    .gpio_rdata (gpio_rdata),
    .gpio_ready (gpio_ready),
    .gpio_mode  (gpio_mode),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rdata;
    logic [N-1:0] mode;
    logic [N-1:0] out;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the architectural registers plus a history of pin
  // values, one entry per clock edge, used for the IN read latency.
  logic [N-1:0] mode_m;
  logic [N-1:0] out_m;
  logic [N-1:0] in_hist[$];

  function automatic void model_reset();
    mode_m = '0;
    out_m  = '0;
    in_hist.delete();
    in_hist.push_back('0);
    in_hist.push_back('0);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One bus cycle: set inputs, predict what the next rising edge yields.
  task automatic drive(input logic we, input logic [3:0] addr,
                       input logic [W-1:0] wdata, input logic [N-1:0] gin);
    exp_t         e;
    logic [N-1:0] in_seen;
    @(negedge clk);
    gpio_we    = we;
    gpio_addr  = addr;
    gpio_wdata = wdata;
    gpio_in    = gin;
    in_hist.push_back(gin);
`ifdef SOC_GPIO_IN_SYNC_EN
    in_seen = in_hist[in_hist.size()-3];
`else
    in_seen = gin;
`endif
    if (in_hist.size() > 3) void'(in_hist.pop_front());
    case (addr)
      4'h0:    e.rdata = W'(mode_m);
      4'h4:    e.rdata = W'(out_m);
      4'h8:    e.rdata = W'(in_seen);
      default: e.rdata = '0;
    endcase
    if (we) begin
      if (addr == 4'h0) mode_m = wdata[N-1:0];
      if (addr == 4'h4) out_m  = wdata[N-1:0];
      if (addr == 4'hC) out_m  = out_m ^ wdata[N-1:0];
    end
    e.mode = mode_m;
    e.out  = out_m;
    sb.push_back(e);
  endtask

  // Monitor: one response per rising edge once the block is running.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata", gpio_rdata, e.rdata);
        check("mode", W'(gpio_mode), W'(e.mode));
        check("out", W'(gpio_out), W'(e.out));
        check("ready", W'(gpio_ready), 32'h1);
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    logic [N-1:0] g;
    int           budget;

    rst        = 1'b1;
    gpio_we    = 1'b0;
    gpio_addr  = 4'h0;
    gpio_wdata = '0;
    gpio_in    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mode", W'(gpio_mode), 32'h0);
    check("rst_out", W'(gpio_out), 32'h0);
    check("rst_rdata", gpio_rdata, 32'h0);
    check("rst_ready", W'(gpio_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", W'(gpio_ready), 32'h0);
    @(posedge clk);
    #1;
    check("ready_first_edge", W'(gpio_ready), 32'h1);

    // Directed sequence.
    drive(1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0);
    drive(1'b1, 4'h4, 32'hAAAA_AAAA, 32'h0);
    drive(1'b0, 4'h4, 32'h0, 32'h0);
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    repeat (3) drive(1'b0, 4'h8, 32'h0, 32'h5555_5555);
    drive(1'b1, 4'h4, 32'h3333_3333, 32'h7777_7777);
    repeat (3) drive(1'b0, 4'h8, 32'h0, 32'h7777_7777);
    drive(1'b1, 4'hC, 32'h0000_FFFF, 32'h7777_7777);
    drive(1'b0, 4'hC, 32'h0, 32'h7777_7777);
    drive(1'b1, 4'h8, 32'h1234_5678, 32'h7777_7777);
    drive(1'b0, 4'h4, 32'h0, 32'h7777_7777);
    // Toggle followed immediately by a plain OUT write.
    drive(1'b1, 4'hC, 32'hF0F0_F0F0, 32'h0);
    drive(1'b1, 4'h4, 32'h0F0F_0F0F, 32'h0);
    // Unmapped addresses: writes ignored, reads zero.
    drive(1'b1, 4'h2, 32'hDEAD_BEEF, 32'h0);
    drive(1'b0, 4'h1, 32'h0, 32'h0);

    // Random OUT write / pin pairs, each followed by IN reads.
    for (int i = 0; i < 5; i++) begin
      d = $urandom();
      g = $urandom();
      drive(1'b1, 4'h4, d, g);
      repeat (3) drive(1'b0, 4'h8, 32'h0, g);
    end

    // Fully random traffic over the whole address space.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(), $urandom());
    end

    // Reset in the middle of a write: nothing lands, everything clears.
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    gpio_we    = 1'b1;
    gpio_addr  = 4'h4;
    gpio_wdata = 32'hFFFF_FFFF;
    rst        = 1'b1;
    #1;
    check("midrst_out", W'(gpio_out), 32'h0);
    check("midrst_ready", W'(gpio_ready), 32'h0);
    @(posedge clk);
    #1;
    check("midrst_out_edge", W'(gpio_out), 32'h0);
    check("midrst_rdata", gpio_rdata, 32'h0);
    @(negedge clk);
    gpio_we = 1'b0;
    model_reset();
    rst = 1'b0;
    drive(1'b0, 4'h4, 32'h0, 32'h0);
    drive(1'b1, 4'h0, 32'h0000_00F0, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);

    // Drain with a bounded wait.
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_gpio.md
# soc_gpio

Memory-mapped general-purpose I/O block on the SoC peripheral bus. It holds a per-pin direction (mode) register and an output data register, and samples the input pins. Everything is exposed through a small 4-bit-addressed register window with single-cycle writes and registered reads. Pad muxing (driving `gpio_out` when `gpio_mode` is 1) is done outside this block.

## Interface
- `IO_MAP_WIDTH`, default 32: bus data width.
- `NUM_GPIO`, default 32: pin count.
  - Must satisfy `NUM_GPIO <= IO_MAP_WIDTH`.
- `clk` in, 1: the single clock; all state is updated on its rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `gpio_wdata` in, IO_MAP_WIDTH: write data.
- `gpio_we` in, 1: write enable, sampled on the rising edge.
- `gpio_addr` in, 4: byte address of the register.
- `gpio_rdata` out, IO_MAP_WIDTH: registered read data.
- `gpio_ready` out, 1: block ready / access complete.
- `gpio_mode` out, NUM_GPIO: direction per pin, 1 = output, 0 = input.
- `gpio_out` out, NUM_GPIO: output data register, unmasked.
- `gpio_in` in, NUM_GPIO: pin input levels.

## Operation
- Register map, full 4-bit decode; any other address reads 0 and ignores writes.
  - 0x0 MODE: read/write.
  - 0x4 OUT: read/write.
  - 0x8 IN: read-only; writes are ignored.
  - 0xC OUT_TGL: write-only, reads 0. A write XORs `gpio_wdata[NUM_GPIO-1:0]` into OUT.
- Write: when `gpio_we` = 1 at a rising edge, the addressed register takes `gpio_wdata[NUM_GPIO-1:0]`. Upper bits are ignored.
- Read: every rising edge, `gpio_rdata` loads the addressed register, zero-extended to IO_MAP_WIDTH. No read strobe is required.
  - Reads occur whether or not `gpio_we` is high.
  - During a write cycle, `gpio_rdata` captures the pre-write value.
- `gpio_out` always drives the OUT register, regardless of `gpio_mode`. Switching a pin to input does not change OUT.
- IN reflects `gpio_in` for all pins, regardless of mode.
- `gpio_ready`: 0 in reset, 1 from the first rising edge after `rst` deasserts, and stays 1. Every access completes in one cycle, so there are no wait states.

## Timing
- Reset (asynchronous) forces `gpio_mode` = 0 (all pins input), `gpio_out` = 0, `gpio_rdata` = 0, `gpio_ready` = 0. Reset asserted mid-access aborts it, and no write takes effect.
- Write latency: the register and the corresponding output change on the same rising edge that samples `gpio_we`.
- Read latency: `gpio_rdata` is valid one cycle after `gpio_addr` is presented.
  - IN path without the synchronizer: a `gpio_in` change is visible in `gpio_rdata` after one rising edge.
- Back-to-back writes are accepted every cycle. Writing OUT and changing `gpio_in` in the same cycle are independent.
- OUT_TGL write followed by an OUT write in the next cycle: each applies in its own cycle.

## Configuration
- `SOC_GPIO_IN_SYNC_EN`:
  - Defined: `gpio_in` passes through a 2-flop synchronizer, reset to 0, before IN. IN read latency from a pin change becomes 3 edges.
  - Undefined (default): IN samples `gpio_in` directly into the read register with no synchronizer.

## Structure
- Package `soc_gpio_pkg`: address constants `GPIO_ADDR_MODE` = 4'h0, `GPIO_ADDR_OUT` = 4'h4, `GPIO_ADDR_IN` = 4'h8, `GPIO_ADDR_TGL` = 4'hC.
- One sub-module, `gpio_sync`: parameterized-width 2-flop synchronizer with async active-high reset. It is instantiated only under `SOC_GPIO_IN_SYNC_EN`.
- Everything else is flat: decode, register file and read mux.

## Test plan
- Reset, then release: `gpio_mode` = 0, `gpio_out` = 0, `gpio_rdata` = 0, `gpio_ready` = 0 during reset and 1 after the first edge.
- Write 0x0 = 0xFFFFFFFF -> `gpio_mode` = 0xFFFFFFFF. Then write 0x4 = 0xAAAAAAAA -> `gpio_out` = 0xAAAAAAAA, and a read of 0x4 returns 0xAAAAAAAA.
- Write 0x0 = 0 -> `gpio_mode` = 0, and `gpio_out` stays 0xAAAAAAAA. Set `gpio_in` = 0x55555555 with addr 0x8 -> `gpio_rdata` = 0x55555555 one edge later.
- In the same cycle, write 0x4 = 0x33333333 and set `gpio_in` = 0x77777777, then read 0x8 -> `gpio_out` = 0x33333333 and `gpio_rdata` = 0x77777777.
- OUT = 0x33333333, write 0xC = 0x0000FFFF -> `gpio_out` = 0x3333CCCC. Read 0xC returns 0. Write 0x8 = 0x12345678 has no effect.
- Five random write(0x4)/`gpio_in` pairs -> `gpio_out` equals the written data and `gpio_rdata` equals `gpio_in` after one edge. With `SOC_GPIO_IN_SYNC_EN`, after three edges.
